controller_hub: RTL and testbench

Parametrised multi-player successor to the single-player controller front end. Samples raw joystick and button pins for `NUM_PLAYERS` players and synchronises each bit. Debounces each bit with its own counter, then produces active-high stable levels plus one-cycle press and release pulses. Each player also gets an attack-buffer latch that holds the attack until the game FSM acknowledges it. Sits between the Pmod JA/JB pins and the game logic.

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/ctrl_debounce.sv | 61 ++++++
 rtl/controller_hub.sv | 82 ++++++++
 tb/tb_controller_hub.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants and helpers for the multi-player controller front end.
// Used by controller_hub and ctrl_debounce.
package ctrl_pkg;

  localparam int unsigned BTNS_PER_PLAYER = 6;

  localparam int unsigned BTN_LEFT   = 0;
  localparam int unsigned BTN_RIGHT  = 1;
  localparam int unsigned BTN_UP     = 2;
  localparam int unsigned BTN_DOWN   = 3;
  localparam int unsigned BTN_ATTACK = 4;
  localparam int unsigned BTN_SHIELD = 5;

  localparam logic [BTNS_PER_PLAYER-1:0] ACTIVE_LOW_MASK_DEFAULT = 6'b001111;

  typedef logic [BTNS_PER_PLAYER-1:0] btn_vec_t;

  // Opposing directions: left+right cancel out, up wins over down.
  function automatic btn_vec_t socd_clean(input btn_vec_t b);
    btn_vec_t c;
    c = b;
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      c[BTN_LEFT]  = 1'b0;
      c[BTN_RIGHT] = 1'b0;
    end
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      c[BTN_DOWN] = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/ctrl_debounce.sv
// Single-bit input conditioning: synchroniser, polarity fix and debounce counter.
// o_stable is active-high and changes only after DEBOUNCE_CYCLES agreeing samples.
module ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter bit          RESET_PIN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_stable
);

  localparam int unsigned   CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CntW-1:0]        r_cnt;
  logic                   r_stable;
  logic [CntW-1:0]        w_cnt_nxt;
  logic                   w_stable_nxt;
  logic                   w_sample;

  // Reload with the released pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_PIN}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  assign w_sample = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    if (w_sample == r_stable) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CntMax) begin
      w_stable_nxt = w_sample;
      w_cnt_nxt    = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/controller_hub.sv
// Multi-player controller front end: debounced levels, press/release pulses, attack latch.
// Define CTRL_SOCD_CLEAN_EN to clean opposing directions before the edge logic.
module controller_hub
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic [BTNS_PER_PLAYER-1:0] ACTIVE_LOW_MASK = ACTIVE_LOW_MASK_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] raw_in,
  output logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] btn_level,
  output logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] btn_press,
  output logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] btn_release,
  output logic [NUM_PLAYERS-1:0]                 attack_pending,
  input  logic [NUM_PLAYERS-1:0]                 attack_ack
);

  localparam int unsigned NumBits = NUM_PLAYERS * BTNS_PER_PLAYER;

  logic [NumBits-1:0]     w_stable;
  logic [NumBits-1:0]     w_level;
  logic [NumBits-1:0]     r_level_q;
  logic [NumBits-1:0]     r_press;
  logic [NumBits-1:0]     r_release;
  logic [NUM_PLAYERS-1:0] r_pending;
  logic [NUM_PLAYERS-1:0] w_pending_nxt;

  for (genvar g = 0; g < NumBits; g++) begin : g_bit
    ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[g % BTNS_PER_PLAYER]),
      .RESET_PIN      (ACTIVE_LOW_MASK[g % BTNS_PER_PLAYER])
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_pin   (raw_in[g]),
      .o_stable(w_stable[g])
    );
  end

`ifdef CTRL_SOCD_CLEAN_EN
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_socd
    assign w_level[p*BTNS_PER_PLAYER +: BTNS_PER_PLAYER] =
        socd_clean(w_stable[p*BTNS_PER_PLAYER +: BTNS_PER_PLAYER]);
  end
`else
  assign w_level = w_stable;
`endif

  // A fresh press takes priority over a simultaneous ack.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_pending_nxt[p] = r_press[p*BTNS_PER_PLAYER + BTN_ATTACK] |
                         (r_pending[p] & ~attack_ack[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level_q <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_pending <= '0;
    end else begin
      r_level_q <= w_level;
      r_press   <= w_level & ~r_level_q;
      r_release <= ~w_level & r_level_q;
      r_pending <= w_pending_nxt;
    end
  end

  assign btn_level      = w_level;
  assign btn_press      = r_press;
  assign btn_release    = r_release;
  assign attack_pending = r_pending;

endmodule

// File: tb/tb_controller_hub.sv
// Self-checking bench for controller_hub (2 players, 4-cycle debounce, 2 sync stages).
// Directed scenarios followed by random pin traffic, all checked against a timing model.
module tb_controller_hub;

  localparam int NP   = 2;
  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int NB   = NP * 6;
  localparam logic [5:0]    MASK = 6'b001111;
  localparam logic [NB-1:0] REL  = {MASK, MASK};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] raw_in;
  logic [NB-1:0] btn_level, btn_press, btn_release;
  logic [NP-1:0] attack_pending, attack_ack;

  always #5 clk = ~clk;

  controller_hub #(
    .NUM_PLAYERS    (NP),
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC),
    .ACTIVE_LOW_MASK(MASK)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .raw_in        (raw_in),
    .btn_level     (btn_level),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .attack_pending(attack_pending),
    .attack_ack    (attack_ack)
  );

  // Reference model: pressed-pin history per edge, time-stamped debounce runs.
  logic [NB-1:0] hist[$];
  int            k = 0;
  int            rst_edge = 0;
  int            last_agree[NB];
  int            last_flip[NB];
  logic [NB-1:0] m_stable = '0, m_lvl = '0, m_lvl_q = '0, m_press = '0, m_rel = '0;
  logic [NP-1:0] m_pend = '0;
  int            tests = 0;
  int            fails = 0;

  function automatic logic [NB-1:0] clean(input logic [NB-1:0] s);
    logic [NB-1:0] c;
    c = s;
`ifdef CTRL_SOCD_CLEAN_EN
    for (int p = 0; p < NP; p++) begin
      if (s[6*p] && s[6*p+1]) begin
        c[6*p]   = 1'b0;
        c[6*p+1] = 1'b0;
      end
      if (s[6*p+2] && s[6*p+3]) c[6*p+3] = 1'b0;
    end
`endif
    return c;
  endfunction

  task automatic model_edge(input logic [NB-1:0] raw, input logic [NP-1:0] ack, input logic rst);
    logic [NB-1:0] pressed;
    logic [NB-1:0] new_press, new_rel;
    logic [NP-1:0] new_pend;
    logic          smp;
    int            ks, since;
    pressed = raw ^ REL;
    hist.push_back(pressed);
    if (!rst) begin
      rst_edge = k;
      m_stable = '0; m_lvl = '0; m_lvl_q = '0; m_press = '0; m_rel = '0; m_pend = '0;
      for (int b = 0; b < NB; b++) begin
        last_agree[b] = k;
        last_flip[b]  = k;
      end
    end else begin
      new_press = m_lvl & ~m_lvl_q;
      new_rel   = ~m_lvl & m_lvl_q;
      for (int p = 0; p < NP; p++) new_pend[p] = m_press[6*p+4] | (m_pend[p] & ~ack[p]);
      ks = k - SYNC;
      for (int b = 0; b < NB; b++) begin
        smp = (ks > rst_edge) ? hist[ks][b] : 1'b0;
        since = (last_agree[b] > last_flip[b]) ? last_agree[b] : last_flip[b];
        if (smp == m_stable[b]) begin
          last_agree[b] = k;
        end else if (k - since == DEB) begin
          m_stable[b]  = smp;
          last_flip[b] = k;
        end
      end
      m_lvl_q = m_lvl;
      m_lvl   = clean(m_stable);
      m_press = new_press;
      m_rel   = new_rel;
      m_pend  = new_pend;
    end
    k++;
  endtask

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [NB-1:0] raw, input logic [NP-1:0] ack, input logic rst);
    raw_in     = raw;
    attack_ack = ack;
    rst_n      = rst;
    @(posedge clk);
    model_edge(raw, ack, rst);
    @(negedge clk);
    check("level", btn_level, m_lvl);
    check("press", btn_press, m_press);
    check("release", btn_release, m_rel);
    check("pending", {{(NB-NP){1'b0}}, attack_pending}, {{(NB-NP){1'b0}}, m_pend});
  endtask

  logic [NB-1:0] cur;
  logic [NP-1:0] ack_r;

  initial begin
    raw_in = REL; attack_ack = '0; rst_n = 1'b0;
    @(negedge clk);

    // Reset and idle
    repeat (3) tick(REL, '0, 1'b0);
    check("rst_level", btn_level, '0);
    check("rst_pending", {{(NB-NP){1'b0}}, attack_pending}, '0);
    repeat (8) tick(REL, '0, 1'b1);
    check("idle_press", btn_press, '0);
    check("idle_release", btn_release, '0);

    // Clean press / release of P0 left (active-low)
    cur = REL; cur[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(cur, '0, 1'b1);
      check("left_level", {{(NB-1){1'b0}}, btn_level[0]}, {{(NB-1){1'b0}}, (i >= 5)});
      check("left_press", {{(NB-1){1'b0}}, btn_press[0]}, {{(NB-1){1'b0}}, (i == 6)});
    end
    for (int i = 0; i < 10; i++) begin
      tick(REL, '0, 1'b1);
      check("left_rel", {{(NB-1){1'b0}}, btn_release[0]}, {{(NB-1){1'b0}}, (i == 6)});
    end

    // Glitches on P1 shield (active-high, bit 11)
    cur = REL; cur[11] = 1'b1;
    repeat (3) tick(cur, '0, 1'b1);
    repeat (8) begin
      tick(REL, '0, 1'b1);
      check("glitch_level", {{(NB-1){1'b0}}, btn_level[11]}, '0);
    end
    repeat (3) tick(cur, '0, 1'b1);
    tick(REL, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(cur, '0, 1'b1);
      check("restart_level", {{(NB-1){1'b0}}, btn_level[11]}, {{(NB-1){1'b0}}, (i >= 5)});
    end
    repeat (10) tick(REL, '0, 1'b1);

    // Attack buffer on P0 (bit 4, active-high)
    cur = REL; cur[4] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick(cur, '0, 1'b1);
      check("atk_pend", {{(NB-1){1'b0}}, attack_pending[0]}, {{(NB-1){1'b0}}, (i >= 7)});
    end
    repeat (10) tick(REL, '0, 1'b1);
    check("atk_hold", {{(NB-1){1'b0}}, attack_pending[0]}, {{(NB-1){1'b0}}, 1'b1});
    for (int i = 0; i < 10; i++) begin
      ack_r = (i == 7) ? 2'b01 : 2'b00;
      tick(cur, ack_r, 1'b1);
      if (i == 6) check("atk_press", {{(NB-1){1'b0}}, btn_press[4]}, {{(NB-1){1'b0}}, 1'b1});
      check("atk_collide", {{(NB-1){1'b0}}, attack_pending[0]}, {{(NB-1){1'b0}}, 1'b1});
    end
    tick(cur, 2'b01, 1'b1);
    check("atk_clear", {{(NB-1){1'b0}}, attack_pending[0]}, '0);
    tick(cur, 2'b01, 1'b1);
    check("atk_idle_ack", {{(NB-NP){1'b0}}, attack_pending}, '0);
    repeat (10) tick(REL, '0, 1'b1);

    // Opposing directions on P0
    cur = REL & ~12'h00F;
    repeat (10) tick(cur, '0, 1'b1);
`ifdef CTRL_SOCD_CLEAN_EN
    check("socd_dirs", {{(NB-4){1'b0}}, btn_level[3:0]}, 12'h004);
`else
    check("socd_dirs", {{(NB-4){1'b0}}, btn_level[3:0]}, 12'h00F);
`endif
    repeat (10) tick(REL, '0, 1'b1);

    // Reset in the middle of a debounce on P1 down (bit 9, active-low)
    cur = REL; cur[9] = 1'b0;
    repeat (4) tick(cur, '0, 1'b1);
    tick(cur, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(cur, '0, 1'b1);
      check("mid_rst_level", {{(NB-1){1'b0}}, btn_level[9]}, {{(NB-1){1'b0}}, (i >= 5)});
    end
    repeat (10) tick(REL, '0, 1'b1);

    // Random traffic
    cur = REL;
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
      for (int p = 0; p < NP; p++) ack_r[p] = ($urandom_range(0, 3) == 0);
      tick(cur, ack_r, ($urandom_range(0, 299) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
